// File: rtl/trap_if.sv
// trap_if: bundles the trap sequencer's event, CSR and redirect signals.
//   slave  : the trap_ctrl side (consumes events/CSR reads, drives strobes and redirect)
//   master : the pipeline/CSR/fetch side (drives events/CSR reads, consumes strobes and redirect)
interface trap_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            ecall;
    logic            ebreak;
    logic            illegal;
    logic            mret;
    logic            irq_en;
    logic            irq_ext;
    logic            irq_timer;
    logic [XLEN-3:0] csr_rd_mtvec_base;
    logic [1:0]      csr_rd_mtvec_mode;
    logic [XLEN-1:0] csr_rd_mepc_mepc;
    logic            ent_trap;
    logic [XLEN-1:0] csr_wr_mepc_mepc;
    logic            csr_wr_mcause_interrupt;
    logic [XLEN-2:0] csr_wr_mcause_exception_code;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            busy;

    modport slave (
        input  pc, next_pc, ecall, ebreak, illegal, mret,
               irq_en, irq_ext, irq_timer,
               csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
               redirect_ready,
        output ent_trap, csr_wr_mepc_mepc, csr_wr_mcause_interrupt,
               csr_wr_mcause_exception_code, redirect_valid, redirect_pc, busy
    );

    modport master (
        output pc, next_pc, ecall, ebreak, illegal, mret,
               irq_en, irq_ext, irq_timer,
               csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
               redirect_ready,
        input  ent_trap, csr_wr_mepc_mepc, csr_wr_mcause_interrupt,
               csr_wr_mcause_exception_code, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer. Turns exceptions, mret and enabled interrupts into
// IDLE -> SAVE (one-cycle ent_trap CSR write) -> REDIRECT (held until accepted).
// mret skips SAVE and redirects straight to mepc.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : trap_if.slave (events, CSR reads, CSR write strobe, fetch redirect, busy)
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic   clk,
    input  logic   rst,
    trap_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SAVE, REDIRECT} state_t;

    state_t          state_q;
    logic            ent_trap_q;
    logic            busy_q;
    logic            rv_q;
    logic [XLEN-1:0] rpc_q;
    // The CSR write outputs double as the latched mepc/cause; they are
    // nonzero only while in SAVE.
    logic [XLEN-1:0] mepc_q;
    logic            intr_q;
    logic [XLEN-2:0] code_q;

    // Event decode, fixed priority.
    logic            trap_take;
    logic            mret_take;
    logic            intr_d;
    logic [XLEN-2:0] code_d;

    always_comb begin
        trap_take = 1'b0;
        mret_take = 1'b0;
        intr_d    = 1'b0;
        code_d    = '0;
        if (bus.illegal) begin
            trap_take = 1'b1;
            code_d    = (XLEN-1)'(2);
        end else if (bus.ebreak) begin
            trap_take = 1'b1;
            code_d    = (XLEN-1)'(3);
        end else if (bus.ecall) begin
            trap_take = 1'b1;
            code_d    = (XLEN-1)'(11);
        end else if (bus.mret) begin
            mret_take = 1'b1;
        end else if (bus.irq_en && bus.irq_ext) begin
            trap_take = 1'b1;
            intr_d    = 1'b1;
            code_d    = (XLEN-1)'(11);
        end else if (bus.irq_en && bus.irq_timer) begin
            trap_take = 1'b1;
            intr_d    = 1'b1;
            code_d    = (XLEN-1)'(7);
        end
    end

    // Vectored mode only applies to interrupts; modes 2/3 behave as direct.
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] tvec;
    assign tvec_base = {bus.csr_rd_mtvec_base, 2'b00};
    assign tvec = (bus.csr_rd_mtvec_mode == 2'd1 && intr_q)
                ? tvec_base + {code_q[XLEN-3:0], 2'b00}
                : tvec_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ent_trap_q <= 1'b0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            mepc_q     <= '0;
            intr_q     <= 1'b0;
            code_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trap_take) begin
                        state_q    <= SAVE;
                        ent_trap_q <= 1'b1;
                        busy_q     <= 1'b1;
                        mepc_q     <= intr_d ? bus.next_pc : bus.pc;
                        intr_q     <= intr_d;
                        code_q     <= code_d;
                    end else if (mret_take) begin
                        state_q <= REDIRECT;
                        busy_q  <= 1'b1;
                        rv_q    <= 1'b1;
                        rpc_q   <= bus.csr_rd_mepc_mepc;
                    end
                end
                SAVE: begin
                    state_q    <= REDIRECT;
                    ent_trap_q <= 1'b0;
                    mepc_q     <= '0;
                    intr_q     <= 1'b0;
                    code_q     <= '0;
                    rv_q       <= 1'b1;
                    rpc_q      <= tvec;
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        state_q <= IDLE;
                        rv_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ent_trap                     = ent_trap_q;
    assign bus.csr_wr_mepc_mepc             = mepc_q;
    assign bus.csr_wr_mcause_interrupt      = intr_q;
    assign bus.csr_wr_mcause_exception_code = code_q;
    assign bus.redirect_valid               = rv_q;
    assign bus.redirect_pc                  = rpc_q;
    assign bus.busy                         = busy_q;
endmodule
